// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root datapath: word layout, FSM states and
// the index-to-slice placement used by both the input and output stages.
package sqrt_pkg;
  localparam int DATAIN    = 256;
  localparam int DWORD     = 48;
  localparam int NWORDS    = 6;
  localparam int TAG_W     = 3;
  localparam int PAYLOAD_W = 44;
  localparam int EXT_W     = NWORDS * PAYLOAD_W;

  localparam logic TYPE_RAD = 1'b0;
  localparam logic TYPE_REM = 1'b1;

  typedef enum logic [1:0] {COLLECT, FIRE, WAIT_END} sqrt_state_e;

  // Six 44-bit payloads span 264 bits; the low 8 bits of the last payload fall off the end.
  function automatic logic [DATAIN-1:0] place_word(input logic [DATAIN-1:0] cur,
                                                   input logic [TAG_W-1:0]  idx,
                                                   input logic [PAYLOAD_W-1:0] pl);
    logic [EXT_W-1:0] ext;
    ext = {cur, {(EXT_W-DATAIN){1'b0}}};
    for (int i = 1; i <= NWORDS; i++)
      if (idx == TAG_W'(i)) ext[(NWORDS-i)*PAYLOAD_W +: PAYLOAD_W] = pl;
    return ext[EXT_W-1 -: DATAIN];
  endfunction
endpackage

// File: rtl/din_if.sv
// Host-FIFO / square-root-core side signals of the input deserializer.
interface din_if;
  logic [sqrt_pkg::DWORD-1:0]  rdata;
  logic                        empty;
  logic                        rden;
  logic                        calcend;
  logic [sqrt_pkg::DATAIN-1:0] datain;
  logic                        calcstart;
  logic                        fmt_err;
  logic                        busy;

  modport master (output rdata, empty, calcend,
                  input  rden, datain, calcstart, fmt_err, busy);
  modport slave  (input  rdata, empty, calcend,
                  output rden, datain, calcstart, fmt_err, busy);
endinterface

// File: rtl/din.sv
// Input deserializer: reassembles six tagged FIFO words into a radicand, starts
// the core, then blocks until the core's result emission has finished.
module din
  import sqrt_pkg::*;
#(
  parameter int HOLD = 8
) (
  input logic  clk,
  input logic  rst,
  din_if.slave bus
);
  localparam int HCW = $clog2(HOLD + 1);

  sqrt_state_e       state_q, state_d;
  logic [TAG_W-1:0]  exp_q, exp_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              seen_q, seen_d;
  logic [HCW-1:0]    hold_q, hold_d;
  logic [DATAIN-1:0] datain_q, datain_d;
  logic              rden, calcstart, fmt_err;

  logic [TAG_W-1:0]     tag;
  logic                 typ;
  logic [PAYLOAD_W-1:0] pl;
  logic                 bad;

  assign tag = bus.rdata[DWORD-1 -: TAG_W];
  assign typ = bus.rdata[PAYLOAD_W];
  assign pl  = bus.rdata[PAYLOAD_W-1:0];
  assign bad = (typ != TYPE_RAD) || (tag == '0) || (tag > TAG_W'(NWORDS));

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    busy_d    = busy_q;
    seen_d    = seen_q;
    hold_d    = hold_q;
    datain_d  = datain_q;
    pend_d    = 1'b0;
    rden      = 1'b0;
    calcstart = 1'b0;
    fmt_err   = 1'b0;
    case (state_q)
      COLLECT: begin
        // One outstanding read; the word arrives while pend_q is high.
        rden   = !bus.empty && !pend_q && !rst;
        pend_d = rden;
        if (pend_q) begin
          if (bad) begin
            fmt_err = 1'b1;
            exp_d   = TAG_W'(1);
            busy_d  = 1'b0;
          end else if (tag == exp_q) begin
            datain_d = place_word(datain_q, tag, pl);
            busy_d   = 1'b1;
            if (tag == TAG_W'(NWORDS)) begin
              state_d = FIRE;
              exp_d   = TAG_W'(1);
            end else begin
              exp_d = exp_q + 1'b1;
            end
          end else if (tag == TAG_W'(1)) begin
            fmt_err  = 1'b1;
            datain_d = place_word(datain_q, TAG_W'(1), pl);
            exp_d    = TAG_W'(2);
            busy_d   = 1'b1;
          end else begin
            fmt_err = 1'b1;
            exp_d   = TAG_W'(1);
            busy_d  = 1'b0;
          end
        end
      end
      FIRE: begin
        calcstart = 1'b1;
        state_d   = WAIT_END;
        hold_d    = '0;
        seen_d    = 1'b0;
      end
      WAIT_END: begin
        // calcend counts only once it has been low here, so a stale high is ignored.
        if (!bus.calcend) begin
          hold_d = '0;
          seen_d = 1'b1;
        end else if (seen_q) begin
          if (hold_q == HCW'(HOLD - 1)) begin
            state_d = COLLECT;
            busy_d  = 1'b0;
            exp_d   = TAG_W'(1);
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      exp_q    <= TAG_W'(1);
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      seen_q   <= 1'b0;
      hold_q   <= '0;
      datain_q <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      seen_q   <= seen_d;
      hold_q   <= hold_d;
      datain_q <= datain_d;
    end
  end

  assign bus.rden      = rden;
  assign bus.calcstart = calcstart;
  assign bus.fmt_err   = fmt_err;
  assign bus.busy      = busy_q;
  assign bus.datain    = datain_q;
endmodule

// File: tb/tb_din.sv
// Bench for din: a word-level model of radicand assembly and release timing,
// fed by directed sequences and randomized word batches through a FIFO model.
module tb_din;
  import sqrt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  din_if bus();
  din #(.HOLD(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DWORD-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.empty = (wr_ptr == rd_ptr);
  always @(posedge clk)
    if (bus.rden) begin
      bus.rdata <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end

  logic [PAYLOAD_W-1:0] slot [1:6];
  int m_exp;
  bit m_busy;
  int n_vec = 0;
  int n_err = 0;
  bit hq[$];

  function automatic logic [DATAIN-1:0] m_datain();
    logic [PAYLOAD_W-1:0] s6;
    s6 = slot[6];
    return {slot[1], slot[2], slot[3], slot[4], slot[5], s6[43:8]};
  endfunction

  function automatic logic [DWORD-1:0] mk(input int idx, input bit typ, input logic [PAYLOAD_W-1:0] p);
    logic [2:0] i3;
    i3 = idx[2:0];
    return {i3, typ, p};
  endfunction

  function automatic logic [PAYLOAD_W-1:0] rnd44();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [DATAIN-1:0] obs, input logic [DATAIN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_exp  = 1;
    m_busy = 0;
    for (int i = 1; i <= 6; i++) slot[i] = '0;
  endtask

  task automatic model_word(input logic [DWORD-1:0] w, output bit efmt, output bit fired);
    int idx;
    idx   = int'(w[47:45]);
    efmt  = 0;
    fired = 0;
    if (w[44] || idx == 0 || idx == 7) begin
      efmt = 1; m_exp = 1; m_busy = 0;
    end else if (idx == m_exp) begin
      slot[idx] = w[43:0];
      m_busy = 1;
      if (idx == 6) begin fired = 1; m_exp = 1; end
      else m_exp = m_exp + 1;
    end else if (idx == 1) begin
      efmt = 1; slot[1] = w[43:0]; m_exp = 2; m_busy = 1;
    end else begin
      efmt = 1; m_exp = 1; m_busy = 0;
    end
  endtask

  task automatic push(input logic [DWORD-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic wait_pop(output bit ok);
    int p0;
    p0 = rd_ptr;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_ptr != p0) begin ok = 1; break; end
    end
    chk("pop_seen", ok, 1);
  endtask

  // Call at a negedge; returns at the negedge after the word's capture cycle.
  task automatic consume(input logic [DWORD-1:0] w, output bit fired);
    bit ok, efmt;
    fired = 0;
    wait_pop(ok);
    if (!ok) return;
    model_word(w, efmt, fired);
    chk("rden_pend", bus.rden, 0);
    chk("fmt_err", bus.fmt_err, efmt);
    @(negedge clk);
    chk("datain", bus.datain, m_datain());
    chk("busy", bus.busy, m_busy);
    chk("calcstart", bus.calcstart, fired);
    chk("fmt_clr", bus.fmt_err, 0);
  endtask

  task automatic apply(input logic [DWORD-1:0] w, output bit fired);
    push(w);
    consume(w, fired);
  endtask

  task automatic hq_add(input bit v, input int n);
    for (int i = 0; i < n; i++) hq.push_back(v);
  endtask

  // Starts at the calcstart negedge; drives calcend from hq one cycle at a time.
  task automatic hold_phase();
    bit seen, rel;
    int run, i;
    seen = 0; rel = 0; run = 0; i = 0;
    while (1) begin
      @(negedge clk);
      if (i > 0) begin
        if (rel) begin chk("busy_release", bus.busy, 0); break; end
        chk("busy_hold", bus.busy, 1);
        chk("rden_hold", bus.rden, 0);
        chk("cs_hold", bus.calcstart, 0);
        chk("datain_hold", bus.datain, m_datain());
      end
      if (i >= hq.size()) break;
      bus.calcend = hq[i];
      if (!hq[i]) begin seen = 1; run = 0; end
      else if (seen) run++;
      rel = (run >= 8);
      i++;
    end
    bus.calcend = 1'b0;
    if (rel) begin m_busy = 0; m_exp = 1; end
    hq = {};
  endtask

  logic [PAYLOAD_W-1:0] pA [1:6];
  logic [DWORD-1:0] batch [0:5];
  bit f, ok;
  int g;

  initial begin
    rst = 1'b1;
    bus.calcend = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rden", bus.rden, 0);
    chk("rst_cs", bus.calcstart, 0);
    chk("rst_fmt", bus.fmt_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_datain", bus.datain, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full load with fixed payloads, long low then 8 high cycles of calcend.
    pA[1] = 44'hAAAAAAAAAAA; pA[2] = 44'hBBBBBBBBBBB; pA[3] = 44'hCCCCCCCCCCC;
    pA[4] = 44'hDDDDDDDDDDD; pA[5] = 44'hEEEEEEEEEEE; pA[6] = 44'h123456789AB;
    for (int i = 1; i <= 6; i++) apply(mk(i, 0, pA[i]), f);
    chk("t1_fire", f, 1);
    chk("t1_concat", bus.datain, {pA[1], pA[2], pA[3], pA[4], pA[5], 36'h123456789});
    hq_add(0, 20); hq_add(1, 8);
    hold_phase();

    // Skip from idx2 to idx4, then a clean reload.
    apply(mk(1, 0, rnd44()), f);
    apply(mk(2, 0, rnd44()), f);
    apply(mk(4, 0, rnd44()), f);
    chk("t2_busy_drop", bus.busy, 0);
    for (int i = 1; i <= 6; i++) apply(mk(i, 0, rnd44()), f);
    chk("t2_fire", f, 1);
    // Stale calcend high, then a premature 5-cycle pulse, with a word waiting in the FIFO.
    push(mk(1, 0, 44'h0F0F0F0F0F0));
    hq_add(1, 3); hq_add(0, 2); hq_add(1, 5); hq_add(0, 4); hq_add(1, 8);
    hold_phase();
    consume(mk(1, 0, 44'h0F0F0F0F0F0), f);

    // idx1 arriving mid-sequence restarts with expected idx2.
    apply(mk(2, 0, rnd44()), f);
    apply(mk(1, 0, 44'h55555555555), f);
    for (int i = 2; i <= 6; i++) apply(mk(i, 0, rnd44()), f);
    chk("t3_fire", f, 1);
    chk("t3_top", bus.datain[255:212], 44'h55555555555);
    hq_add(0, 1); hq_add(1, 8);
    hold_phase();

    // Type bit set on an otherwise valid index.
    apply(48'h9000_0000_0001, f);

    // Reset while a read is outstanding.
    for (int i = 1; i <= 3; i++) apply(mk(i, 0, rnd44()), f);
    push(mk(4, 0, rnd44()));
    wait_pop(ok);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_rden", bus.rden, 0);
    chk("mrst_cs", bus.calcstart, 0);
    chk("mrst_fmt", bus.fmt_err, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_datain", bus.datain, 0);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 6; i++) apply(mk(i, 0, rnd44()), f);
    chk("t6_fire", f, 1);
    hq_add(0, 2); hq_add(1, 8);
    hold_phase();

    // Randomized batches, pushed ahead so reads run back to back.
    g = 1;
    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 7) == 0) batch[k] = mk($urandom_range(0, 7), 0, rnd44());
        else if ($urandom_range(0, 15) == 0) batch[k] = mk(g, 1, rnd44());
        else batch[k] = mk(g, 0, rnd44());
        g = (g == 6) ? 1 : g + 1;
      end
      for (int k = 0; k < 6; k++) push(batch[k]);
      for (int k = 0; k < 6; k++) begin
        consume(batch[k], f);
        if (f) begin
          hq_add(1, $urandom_range(0, 3));
          hq_add(0, $urandom_range(1, 4));
          hq_add(1, $urandom_range(0, 7));
          hq_add(0, 1);
          hq_add(1, 8);
          hold_phase();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
